// File: rtl/opu_line_sched_pkg.sv
// Shared types and constants for the OPU line scheduler.
// State encoding, mode bit positions, kernel sizes and counter width.
package opu_line_sched_pkg;

    localparam int CNT_W = 9;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = 9'd1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam int MODE_B0 = 0;
    localparam int MODE_B1 = 1;
    localparam int MODE_B2 = 2;

    localparam logic [2:0] K_NONE = 3'd0;
    localparam logic [2:0] K1     = 3'd1;
    localparam logic [2:0] K3     = 3'd3;
    localparam logic [2:0] K4     = 3'd4;

    // Picture configuration captured on start.
    typedef struct packed {
        logic [3:0] mode;
        logic [7:0] size;
        logic       pad;
    } cfg_t;

    // Kernel edge from the mode bits; lowest set bit wins.
    function automatic logic [2:0] kernel_of(input logic [2:0] m);
        logic [2:0] k;
        k = K_NONE;
        if (m[MODE_B0]) begin
            k = K1;
        end else if (m[MODE_B1]) begin
            k = K3;
        end else if (m[MODE_B2]) begin
            k = K4;
        end
        return k;
    endfunction

endpackage

// File: rtl/opu_line_sched_geom.sv
// opu_geom_calc: combinational line-length computation.
// Ports: mode_i/size_i/pad_i config in; len_o (L, 9 bit) and err_o out.
module opu_geom_calc
    import opu_line_sched_pkg::*;
(
    input  logic [3:0]       mode_i,
    input  logic [7:0]       size_i,
    input  logic             pad_i,
    output logic [CNT_W-1:0] len_o,
    output logic             err_o
);

    logic [CNT_W-1:0] w;
    logic [2:0]       k;
    logic signed [9:0] l;
    logic             unused_mode_b3;

    // Bit 3 of the mode selects no kernel.
    assign unused_mode_b3 = mode_i[3];

    always_comb begin
        w = {1'b0, size_i} + {7'd0, pad_i, 1'b0};
        k = kernel_of(mode_i[2:0]);
        // Signed so that a kernel larger than the padded edge goes negative.
        l = $signed({1'b0, w}) + 10'sd1 - $signed({7'd0, k});
        err_o = (k == K_NONE) || (l < 10'sd1);
        len_o = l[CNT_W-1:0];
    end

endmodule

// File: rtl/opu_line_sched.sv
// opu_line_sched: raster scheduler emitting update/clear strobes per line.
// Ports: SYS_CLK, SYS_NRST, start_i, abort_i, stall_i, mode_i, pic_size,
//        padding in; ctrl_update_o, ctrl_reset_o, busy_o, done_o, err_o,
//        row_o, col_o out. All outputs come from registers only.
module opu_line_sched
    import opu_line_sched_pkg::*;
(
    input  logic             SYS_CLK,
    input  logic             SYS_NRST,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             stall_i,
    input  logic [3:0]       mode_i,
    input  logic [7:0]       pic_size,
    input  logic             padding,
    output logic             ctrl_update_o,
    output logic             ctrl_reset_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] row_o,
    output logic [CNT_W-1:0] col_o
);

    state_t           state_q, state_d;
    cfg_t             cfg_q, cfg_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic             upd_q, upd_d;
    logic             clr_q, clr_d;
    logic             err_q, err_d;

    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] last;
    logic             geom_err;

    opu_geom_calc u_geom (
        .mode_i (cfg_q.mode),
        .size_i (cfg_q.size),
        .pad_i  (cfg_q.pad),
        .len_o  (len),
        .err_o  (geom_err)
    );

    assign last = len - CNT_ONE;

    // Strobes are decided one edge ahead: upd_q/clr_q describe the
    // cycle being entered, so stall_i takes effect on the next cycle.
    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        row_d   = row_q;
        col_d   = col_q;
        upd_d   = 1'b0;
        clr_d   = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_LOAD;
                    cfg_d   = '{mode: mode_i,
                                size: pic_size,
                                pad:  padding};
                    row_d   = CNT_ZERO;
                    col_d   = CNT_ZERO;
                    clr_d   = 1'b1;
                end
            end
            ST_LOAD: begin
                if (abort_i) begin
                    state_d = ST_DONE;
                    clr_d   = 1'b1;
                end else if (geom_err) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_RUN;
                    upd_d   = !stall_i;
                end
            end
            ST_RUN: begin
                if (abort_i) begin
                    state_d = ST_DONE;
                    clr_d   = 1'b1;
                end else if (upd_q) begin
                    if (col_q == last) begin
                        state_d = ST_GAP;
                        col_d   = CNT_ZERO;
                        clr_d   = 1'b1;
                    end else begin
                        col_d = col_q + CNT_ONE;
                        upd_d = !stall_i;
                    end
                end else begin
                    upd_d = !stall_i;
                end
            end
            ST_GAP: begin
                if (abort_i) begin
                    state_d = ST_DONE;
                    clr_d   = 1'b1;
                end else begin
                    row_d = row_q + CNT_ONE;
                    if (row_q == last) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                        upd_d   = !stall_i;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
        if (!SYS_NRST) begin
            state_q <= ST_IDLE;
            cfg_q   <= '0;
            row_q   <= CNT_ZERO;
            col_q   <= CNT_ZERO;
            upd_q   <= 1'b0;
            clr_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            row_q   <= row_d;
            col_q   <= col_d;
            upd_q   <= upd_d;
            clr_q   <= clr_d;
            err_q   <= err_d;
        end
    end

    assign ctrl_update_o = upd_q;
    assign ctrl_reset_o  = clr_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = (state_q == ST_DONE);
    assign err_o         = err_q;
    assign row_o         = row_q;
    assign col_o         = col_q;

endmodule
